// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment scan driver.
// Glyphs are stored active-high as {g,f,e,d,c,b,a}; output polarity is applied at decode.
package seg7_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REQ    = 2'd1,
        S_CAPT   = 2'd2,
        S_COMMIT = 2'd3
    } state_t;

    localparam logic [6:0] SEG_OFF = 7'h00;

    localparam logic [6:0] GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [6:0] seg7_glyph(input logic [3:0] digit, input logic blank);
        return blank ? SEG_OFF : GLYPH[digit];
    endfunction

endpackage

// File: rtl/seg7_scan_drv_if.sv
// Converter-to-display link: request pulse out, strobed serial BCD digits in.
// master = converter side, slave = display driver side.
interface seg7_scan_drv_if #(
    parameter int DEC_DIGITS = 4
);
    logic                  req_o;
    logic [3:0]            digit_i;
    logic [DEC_DIGITS-1:0] digit_vld_i;

    modport master (input req_o, output digit_i, output digit_vld_i);
    modport slave  (output req_o, input digit_i, input digit_vld_i);
endinterface

// File: rtl/seg7_dec.sv
// Combinational 4-bit to 7-segment glyph lookup with blanking and output polarity.
module seg7_dec
    import seg7_pkg::*;
(
    input  logic [3:0] i_digit,
    input  logic       i_blank,
    input  logic       i_active_low,
    output logic [6:0] o_seg
);

    logic [6:0] w_glyph;

    always_comb begin
        w_glyph = seg7_glyph(i_digit, i_blank);
        o_seg   = w_glyph ^ {7{i_active_low}};
    end

endmodule

// File: rtl/seg7_scan_drv.sv
// Requests BCD conversions periodically, captures the digit stream into a shadow
// buffer, commits whole frames and multiplexes the display buffer onto the digits.
module seg7_scan_drv
    import seg7_pkg::*;
#(
    parameter int DEC_DIGITS     = 4,
    parameter int SCAN_DIV       = 50000,
    parameter int UPDATE_DIV     = 5000000,
    parameter int TIMEOUT        = 256,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    seg7_scan_drv_if.slave        cnv,
    input  logic                  blank_lz_i,
    input  logic [DEC_DIGITS-1:0] dp_i,
    output logic [6:0]            seg_o,
    output logic                  dp_o,
    output logic [DEC_DIGITS-1:0] an_o
);

    localparam int unsigned IDX_W = $clog2(DEC_DIGITS);
    localparam int unsigned SCN_W = $clog2(SCAN_DIV);
    localparam int unsigned UPD_W = $clog2(UPDATE_DIV);
    localparam int unsigned TO_W  = $clog2(TIMEOUT);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DEC_DIGITS - 1);
    localparam logic [SCN_W-1:0] SCN_MAX  = SCN_W'(SCAN_DIV - 1);
    localparam logic [UPD_W-1:0] UPD_MAX  = UPD_W'(UPDATE_DIV - 1);
    localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT - 1);
    localparam logic             POL      = (SEG_ACTIVE_LOW != 0);

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic [UPD_W-1:0]            r_upd;
    logic [TO_W-1:0]             r_to;
    logic [IDX_W-1:0]            r_exp;
    logic                        r_req;
    logic [DEC_DIGITS-1:0][3:0]  r_shadow;
    logic [DEC_DIGITS-1:0][3:0]  r_disp;
    logic                        w_tick;
    logic                        w_cap;
    logic [DEC_DIGITS-1:0]       w_exp_oh;

    logic [SCN_W-1:0]            r_scn;
    logic [IDX_W-1:0]            r_idx;
    logic [6:0]                  r_seg;
    logic                        r_dp;
    logic [DEC_DIGITS-1:0]       r_an;
    logic                        w_wrap;
    logic [IDX_W-1:0]            w_idx_nxt;
    logic [DEC_DIGITS-1:0][3:0]  w_src;
    logic [DEC_DIGITS-1:0]       w_lz;
    logic                        w_allz;
    logic                        w_blank;
    logic [3:0]                  w_digit;
    logic [6:0]                  w_seg;

    assign w_tick   = (r_upd == UPD_MAX);
    assign w_exp_oh = DEC_DIGITS'(1) << r_exp;

    always_comb begin
        w_state_nxt = r_state;
        w_cap       = 1'b0;
        case (r_state)
            S_IDLE:   if (w_tick) w_state_nxt = S_REQ;
            S_REQ:    w_state_nxt = S_CAPT;
            S_CAPT: begin
                if (r_to == TO_MAX) w_state_nxt = S_IDLE;
                // A multi-hot strobe matches neither branch and is ignored.
                if (cnv.digit_vld_i == w_exp_oh) begin
                    w_cap = 1'b1;
                    if (r_exp == IDX_LAST) w_state_nxt = S_COMMIT;
                end else if ($onehot(cnv.digit_vld_i)) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_COMMIT: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_upd    <= '0;
            r_req    <= 1'b0;
            r_exp    <= '0;
            r_to     <= '0;
            r_shadow <= '0;
            r_disp   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_upd   <= w_tick ? '0 : r_upd + UPD_W'(1);
            r_req   <= (w_state_nxt == S_REQ);
            if (r_state == S_REQ) begin
                r_exp <= '0;
                r_to  <= '0;
            end else if (r_state == S_CAPT) begin
                r_to <= r_to + TO_W'(1);
                if (w_cap) begin
                    r_shadow[r_exp] <= cnv.digit_i;
                    r_exp           <= r_exp + IDX_W'(1);
                end
            end
            if (r_state == S_COMMIT) r_disp <= r_shadow;
        end
    end

    assign cnv.req_o = r_req;

    // Bypass the shadow during commit so a slot starting on that edge shows the new frame.
    assign w_src     = (r_state == S_COMMIT) ? r_shadow : r_disp;
    assign w_wrap    = (r_scn == SCN_MAX);
    assign w_idx_nxt = (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);

    always_comb begin
        w_lz   = '0;
        w_allz = 1'b1;
        for (int unsigned k = DEC_DIGITS; k > 0; k--) begin
            w_allz    = w_allz & (w_src[k-1] == 4'd0);
            w_lz[k-1] = w_allz;
        end
    end

    assign w_blank = blank_lz_i & (w_idx_nxt != '0) & w_lz[w_idx_nxt];
    assign w_digit = w_src[w_idx_nxt];

    seg7_dec u_dec (
        .i_digit      (w_digit),
        .i_blank      (w_blank),
        .i_active_low (POL),
        .o_seg        (w_seg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scn <= '0;
            r_idx <= '0;
            r_an  <= {DEC_DIGITS{POL}};
            r_seg <= {7{POL}};
            r_dp  <= POL;
        end else begin
            r_scn <= w_wrap ? '0 : r_scn + SCN_W'(1);
            if (w_wrap) begin
                r_idx <= w_idx_nxt;
                r_an  <= (DEC_DIGITS'(1) << w_idx_nxt) ^ {DEC_DIGITS{POL}};
                r_seg <= w_seg;
                r_dp  <= dp_i[w_idx_nxt] ^ POL;
            end
        end
    end

    assign seg_o = r_seg;
    assign dp_o  = r_dp;
    assign an_o  = r_an;

endmodule
